// File: rtl/patdet_pkg.sv
// +--------------------------------------------------------------------------+
// | patdet_pkg: shared types, defaults and length clamp for pattern_det_ctrl |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package patdet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int C_PAT_W_DEFAULT = 4;
  localparam int C_CNT_W_DEFAULT = 8;

  // A zero length still compares one bit; anything wider than the register is cut to fit.
  function automatic int clamp_len(input int len, input int pat_w);
    if (len < 1) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/patdet_match.sv
// +--------------------------------------------------------------------------+
// | patdet_match: history shift register, fill count and masked compare      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module patdet_match
  import patdet_pkg::*;
#(
  parameter int PAT_W = C_PAT_W_DEFAULT,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match
);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_next_hist;
  logic [PAT_W-1:0] w_mask;
  logic             w_fill_ok;

  assign w_next_hist = {r_hist[PAT_W-2:0], x};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (LEN_W'(i) < len);
    end
  end

  // The current bit counts toward the fill, hence the +1.
  assign w_fill_ok = ((LEN_W+1)'(r_fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len);
  assign match     = shift_en & w_fill_ok &
                     (((w_next_hist ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      r_hist <= w_next_hist;
      if (match && !overlap) begin
        r_fill <= '0;
      end else if (r_fill != LEN_W'(PAT_W)) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_det_ctrl.sv
// +--------------------------------------------------------------------------+
// | pattern_det_ctrl: configurable serial pattern detector with hit limit.   |
// | Option: PATDET_HIT_REG_EN registers hit (one-cycle delayed pulse).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pattern_det_ctrl
  import patdet_pkg::*;
#(
  parameter int PAT_W = C_PAT_W_DEFAULT,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int CNT_W = C_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             clr,
  input  logic             x_valid,
  input  logic             x,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_shift;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;

  assign cfg_ready = (r_state == ST_IDLE) & ~clr;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign match_cnt = r_cnt;

  assign w_accept  = cfg_valid & cfg_ready;
  assign w_shift   = (r_state == ST_RUN) & x_valid & ~clr;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  patdet_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr | w_accept),
    .shift_en (w_shift),
    .x        (x),
    .pattern  (r_pattern),
    .len      (r_len),
    .overlap  (r_overlap),
    .match    (w_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_limit   <= '0;
      r_cnt     <= '0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pattern <= cfg_pattern;
            r_len     <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            r_overlap <= cfg_overlap;
            r_limit   <= cfg_limit;
            r_cnt     <= '0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_match) begin
            r_cnt <= w_cnt_inc;
            if ((r_limit != '0) && (w_cnt_inc == r_limit)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PATDET_HIT_REG_EN
  logic r_hit;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= w_match;
    end
  end

  assign hit = r_hit;
`else
  assign hit = w_match;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_det_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pattern_det_ctrl: directed vector bench for pattern_det_ctrl          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pattern_det_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       clr;
  logic       x_valid;
  logic       x;
  logic       hit;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       rst, clr, cv;
    logic [3:0] pat;
    logic [2:0] len;
    logic       ov;
    logic [7:0] lim;
    logic       xv, x;
    logic       e_hit;
    logic [7:0] e_cnt;
    logic       e_busy, e_done, e_rdy;
  } vec_t;

  vec_t tbl[$];

  pattern_det_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_limit   (cfg_limit),
    .clr         (clr),
    .x_valid     (x_valid),
    .x           (x),
    .hit         (hit),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, c, v, input logic [3:0] p, input logic [2:0] l,
                              input logic o, input logic [7:0] lm, input logic xv, xx, eh,
                              input logic [7:0] ec, input logic eb, ed, er);
    vec_t t;
    t.rst = r; t.clr = c; t.cv = v; t.pat = p; t.len = l; t.ov = o; t.lim = lm;
    t.xv = xv; t.x = xx; t.e_hit = eh; t.e_cnt = ec; t.e_busy = eb; t.e_done = ed; t.e_rdy = er;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  // Drive just after the rising edge, check mid-cycle, then advance one edge.
  task automatic cyc(input vec_t t, input int idx);
    #1;
    rst = t.rst; clr = t.clr; cfg_valid = t.cv; cfg_pattern = t.pat; cfg_len = t.len;
    cfg_overlap = t.ov; cfg_limit = t.lim; x_valid = t.xv; x = t.x;
    @(negedge clk);
    chk("hit",       idx, {7'd0, hit},       {7'd0, t.e_hit});
    chk("match_cnt", idx, match_cnt,         t.e_cnt);
    chk("busy",      idx, {7'd0, busy},      {7'd0, t.e_busy});
    chk("done",      idx, {7'd0, done},      {7'd0, t.e_done});
    chk("cfg_ready", idx, {7'd0, cfg_ready}, {7'd0, t.e_rdy});
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_limit = '0; x_valid = 1'b0; x = 1'b0;
    repeat (2) @(posedge clk);

    //            rst clr cv pat      len   ov lim xv x | hit cnt busy done rdy
    // 1001 overlapping, no limit
    tbl.push_back(mk(1, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4'b1001, 3'd4, 1, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 2, 1, 0, 0));
    // 1001 non-overlapping
    tbl.push_back(mk(0, 0, 1, 4'b1001, 3'd4, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    // 11, len 2, limit 3
    tbl.push_back(mk(0, 0, 1, 4'b0011, 3'd2, 1, 3, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 3, 0, 1, 0));
    // clr blocks cfg in IDLE, then clr beats a matching final bit
    tbl.push_back(mk(0, 1, 1, 4'b1001, 3'd4, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4'b1001, 3'd4, 1, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0));
    // len 0 clamps to 1
    tbl.push_back(mk(0, 0, 1, 4'b0001, 3'd0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 2, 1, 0, 0));
    // len 7 clamps to 4
    tbl.push_back(mk(0, 0, 1, 4'b1001, 3'd7, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    // x_valid gaps inside 1001
    tbl.push_back(mk(0, 0, 1, 4'b1001, 3'd4, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 1,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], i);

    // rst while in DONE
    cyc(mk(0, 0, 1, 4'b0011, 3'd2, 1, 1, 0, 0,  0, 0, 0, 0, 1), 1000);
    cyc(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 1, 0, 0), 1001);
    cyc(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, 0, 1, 0, 0), 1002);
    cyc(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 1, 0, 1, 0), 1003);
    cyc(mk(1, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 1, 0, 1, 0), 1004);
    cyc(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  0, 0, 0, 0, 1), 1005);

    // match_cnt saturates at all-ones with an unlimited run
    cyc(mk(0, 0, 1, 4'b0001, 3'd1, 1, 0, 0, 0,  0, 0, 0, 0, 1), 2000);
    for (int i = 0; i < 260; i++)
      cyc(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 1, 1,  1, (i < 255) ? 8'(i) : 8'hFF, 1, 0, 0), 2001 + i);
    cyc(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 8'hFF, 1, 0, 0), 2300);
    cyc(mk(0, 1, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 8'hFF, 1, 0, 0), 2301);
    cyc(mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 0,  0, 0, 0, 0, 1), 2302);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
